// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode values and the
// fetch-stage state encoding used by the fetch unit and the opcode decoder.
package cpu_pkg;

  localparam int OPC_W     = 4;
  localparam int INSTR_W   = 16;
  localparam int OPERAND_W = 12;
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'd2;
  localparam logic [OPC_W-1:0] OP_STORE = 4'd3;
  localparam logic [OPC_W-1:0] OP_JUMP  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

  // Everything above the highest defined opcode is issued but flagged.
  function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
    return opc > OP_JUMP;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: load has priority over increment; increment wraps
// naturally modulo 2^W.
module pc_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_val;
    else if (inc) pc_d = pc_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue stage: one outstanding imem fetch at a time, the captured word
// is held on the issue port until the decoder takes it, then the PC advances.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [11:0]        operand,
  output logic [ADDR_W-1:0]  issue_pc,
  input  logic               jump_taken,
  output logic               illegal_op,
  output logic [15:0]        instr_count
);
  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic               issue_valid_q, issue_valid_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  issue_pc_q, issue_pc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pc;
  logic               xfer;

  assign xfer = issue_valid_q & issue_ready;

  // Jump target is the low bits of the operand of the instruction leaving.
  pc_reg #(.W(ADDR_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (xfer & jump_taken),
    .inc      (xfer & ~jump_taken),
    .load_val (ir_q[ADDR_W-1:0]),
    .pc       (pc)
  );

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    issue_valid_d = issue_valid_q;
    ir_d          = ir_q;
    issue_pc_d    = issue_pc_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
        end
      end
      // enable is not looked at here: a requested word is always issued.
      ST_FETCH: begin
        if (imem_valid && imem_req_q) begin
          ir_d          = imem_rdata;
          issue_pc_d    = pc;
          imem_req_d    = 1'b0;
          issue_valid_d = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          issue_valid_d = 1'b0;
          cnt_d         = cnt_q + 16'd1;
          if (enable) begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        imem_req_d    = 1'b0;
        issue_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      issue_valid_q <= 1'b0;
      ir_q          <= '0;
      issue_pc_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      issue_valid_q <= issue_valid_d;
      ir_q          <= ir_d;
      issue_pc_q    <= issue_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc;
  assign issue_valid = issue_valid_q;
  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign operand     = ir_q[OPC_LSB-1:0];
  assign issue_pc    = issue_pc_q;
  assign illegal_op  = xfer & is_illegal(ir_q[OPC_MSB:OPC_LSB]);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: imem responder model, a scoreboard of expected
// issues checked on every transfer, and one task per scenario.
module tb_instr_fetch_unit;

  logic        clk, rst_n, enable, imem_valid, issue_ready, jump_taken;
  logic [15:0] imem_rdata;
  logic        imem_req, issue_valid, illegal_op;
  logic [7:0]  imem_addr, issue_pc;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [3:0]  opc;
    logic [11:0] opd;
    logic [7:0]  pc;
    logic        jmp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  bit          imem_auto = 1;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .OPC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .operand(operand), .issue_pc(issue_pc),
    .jump_taken(jump_taken), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // imem: answers a pending request for one cycle, valid never held longer
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (imem_valid) imem_valid = 1'b0;
      else if (imem_auto && rst_n && imem_req) begin
        imem_rdata = mem[imem_addr];
        imem_valid = 1'b1;
      end
    end
  end

  // scoreboard: every transfer pops one expected issue and supplies its jump flag
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (issue_valid && issue_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got op=%h opd=%h pc=%h, required no transfer", opcode, operand, issue_pc);
          jump_taken = 1'b0;
        end else begin
          e = exp_q.pop_front();
          jump_taken = e.jmp;
          exp_count++;
          if ({opcode, operand, issue_pc, illegal_op} !== {e.opc, e.opd, e.pc, (e.opc > 4'd4)}) begin
            errors++;
            $display("FAIL xfer: got op=%h opd=%h pc=%h ill=%b, required op=%h opd=%h pc=%h ill=%b",
                     opcode, operand, issue_pc, illegal_op, e.opc, e.opd, e.pc, (e.opc > 4'd4));
          end
        end
      end else begin
        jump_taken = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic j);
    exp_t e;
    logic [15:0] w;
    w = mem[a];
    e.opc = w[15:12];
    e.opd = w[11:0];
    e.pc  = a;
    e.jmp = j;
    exp_q.push_back(e);
  endtask

  // Runs until the scoreboard is empty and the DUT is idle; drops enable once
  // the last expected instruction is on the issue port.
  task automatic drain(input int budget, output bit to);
    int beyond;
    to = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (issue_valid) begin
        beyond = issue_ready ? exp_q.size() : exp_q.size() - 1;
        if (beyond <= 0) enable = 1'b0;
      end
      if (exp_q.size() == 0 && !issue_valid && !imem_req && !enable) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, issue_valid, opcode, operand, issue_pc, illegal_op, instr_count} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h iv=%b op=%h opd=%h pc=%h ill=%b cnt=%h, required all 0",
               imem_req, imem_addr, issue_valid, opcode, operand, issue_pc, illegal_op, instr_count);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req, issue_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_enable: got req=%b iv=%b, required 0 0", imem_req, issue_valid);
    end
  endtask

  task automatic test_sequential;
    bit to;
    mem[0] = 16'h0005;
    mem[1] = 16'h1003;
    push(8'h00, 1'b0);
    push(8'h01, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    drain(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL seq_timeout: got %0d left, required 0", exp_q.size()); end
    checks++;
    if (instr_count !== 16'd2 || imem_addr !== 8'h02) begin
      errors++;
      $display("FAIL seq_state: got cnt=%0d addr=%h, required cnt=2 addr=02", instr_count, imem_addr);
    end
  endtask

  task automatic test_jump;
    bit to;
    mem[2] = 16'h2000;
    mem[3] = 16'h4010;
    push(8'h02, 1'b0);
    push(8'h03, 1'b1);
    @(posedge clk); #1 enable = 1'b1;
    drain(200, to);
    checks++;
    if (to || imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL jump_taken: got addr=%h to=%b, required addr=10 to=0", imem_addr, to);
    end
    mem[8'h10] = 16'h4003;
    push(8'h10, 1'b1);
    push(8'h03, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    drain(200, to);
    checks++;
    if (to || imem_addr !== 8'h04 || instr_count !== exp_count[15:0]) begin
      errors++;
      $display("FAIL jump_not_taken: got addr=%h cnt=%0d to=%b, required addr=04 cnt=%0d to=0",
               imem_addr, instr_count, to, exp_count);
    end
  endtask

  task automatic test_wrap;
    bit to;
    mem[4]     = 16'h40FF;
    mem[8'hFF] = 16'h0000;
    push(8'h04, 1'b1);
    push(8'hFF, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    drain(200, to);
    checks++;
    if (to || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: got addr=%h to=%b, required addr=00 to=0", imem_addr, to);
    end
    mem[0]     = 16'h4020;
    mem[8'h20] = 16'h4020;
    push(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) push(8'h20, 1'b1);
    @(posedge clk); #1 enable = 1'b1;
    drain(300, to);
    checks++;
    if (to || imem_addr !== 8'h20 || instr_count !== 16'd12) begin
      errors++;
      $display("FAIL tight_loop: got addr=%h cnt=%0d to=%b, required addr=20 cnt=12 to=0", imem_addr, instr_count, to);
    end
  endtask

  task automatic test_stall;
    bit to;
    bit seen = 1'b0;
    issue_ready = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = issue_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_wait: got issue_valid=0, required 1 within 50 cycles"); end
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({issue_valid, imem_req, opcode, operand, issue_pc} !== {1'b1, 1'b0, 4'h4, 12'h020, 8'h20}) begin
        errors++;
        $display("FAIL stall_frozen[%0d]: got iv=%b req=%b op=%h opd=%h pc=%h, required iv=1 req=0 op=4 opd=020 pc=20",
                 c, issue_valid, imem_req, opcode, operand, issue_pc);
      end
      // a stray response while issuing must not disturb the held word
      if (c == 1) begin
        imem_rdata = 16'h3ABC;
        imem_valid = 1'b1;
      end
    end
    push(8'h20, 1'b0);
    @(posedge clk); #1 issue_ready = 1'b1;
    drain(100, to);
    checks++;
    if (to || imem_addr !== 8'h21 || instr_count !== 16'd13) begin
      errors++;
      $display("FAIL stall_release: got addr=%h cnt=%0d to=%b, required addr=21 cnt=13 to=0", imem_addr, instr_count, to);
    end
  endtask

  task automatic test_illegal;
    bit to;
    int pulses = 0;
    mem[8'h21] = 16'hF123;
    mem[8'h22] = 16'h5ABC;
    push(8'h21, 1'b0);
    // enable only for the IDLE->FETCH edge: the fetch must still be issued
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (illegal_op) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL illegal_pulse: got %0d cycles, required 1", pulses); end
    checks++;
    if (exp_q.size() != 0 || imem_req || issue_valid || imem_addr !== 8'h22 || instr_count !== 16'd14) begin
      errors++;
      $display("FAIL enable_drop_fetch: got left=%0d req=%b iv=%b addr=%h cnt=%0d, required left=0 req=0 iv=0 addr=22 cnt=14",
               exp_q.size(), imem_req, issue_valid, imem_addr, instr_count);
    end
    push(8'h22, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    drain(100, to);
    checks++;
    if (to || instr_count !== 16'd15) begin
      errors++;
      $display("FAIL illegal_min: got cnt=%0d to=%b, required cnt=15 to=0", instr_count, to);
    end
  endtask

  task automatic test_reset_mid_fetch;
    bit to;
    bit seen = 1'b0;
    imem_auto = 0;
    @(posedge clk); #1 enable = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = imem_req;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_fetch_wait: got imem_req=0, required 1 within 20 cycles"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, issue_valid, imem_addr, instr_count} !== 26'd0) begin
      errors++;
      $display("FAIL rst_async: got req=%b iv=%b addr=%h cnt=%0d, required all 0", imem_req, issue_valid, imem_addr, instr_count);
    end
    exp_count = 0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rdata = 16'h1234;
    imem_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req, issue_valid, imem_addr} !== 10'd0) begin
      errors++;
      $display("FAIL rst_late_valid: got req=%b iv=%b addr=%h, required 0 0 00", imem_req, issue_valid, imem_addr);
    end
    imem_auto = 1;
    push(8'h00, 1'b0);
    @(posedge clk); #1 enable = 1'b1;
    drain(100, to);
    checks++;
    if (to || instr_count !== 16'd1 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL rst_refetch: got cnt=%0d addr=%h to=%b, required cnt=1 addr=01 to=0", instr_count, imem_addr, to);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; issue_ready = 1'b1; jump_taken = 1'b0;
    imem_valid = 1'b0; imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset;
    test_sequential;
    test_jump;
    test_wrap;
    test_stall;
    test_illegal;
    test_reset_mid_fetch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
